// File: rtl/alarm_tone_gen_pkg.sv
// Shared types for the alarm tone generator: FSM states, zone indices
// and the fixed-priority zone arbiter.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int ZONE1 = 0;
  localparam int ZONE2 = 1;
  localparam int ZONE3 = 2;

  // Lowest-numbered zone wins.
  function automatic logic [2:0] prio_grant(input logic [2:0] req);
    logic [2:0] g;
    g = '0;
    if (req[ZONE1])      g[ZONE1] = 1'b1;
    else if (req[ZONE2]) g[ZONE2] = 1'b1;
    else if (req[ZONE3]) g[ZONE3] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/alarm_tone_gen_if.sv
// Alarm request / speaker status bundle between the detector side and the tone generator.
// No flow control: levels only.
interface alarm_tone_gen_if;
  logic       ena;
  logic [2:0] alarm_in;
  logic       spk;
  logic [2:0] active;
  logic       busy;

  modport master (output ena, output alarm_in, input spk, input active, input busy);
  modport slave  (input ena, input alarm_in, output spk, output active, output busy);
endinterface

// File: rtl/alarm_tone_gen_tone_divider.sv
// Loadable half-period down-counter with a square-wave phase bit; load starts on the high phase.
// hold freezes count and phase; tog_nxt is the phase the next edge will register.
module tone_divider #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] half,
  output logic             tog_nxt
);

  logic [CNT_W-1:0] cnt, cnt_d;
  logic             tog, tog_d;

  always_comb begin
    cnt_d = cnt;
    tog_d = tog;
    if (!hold) begin
      if (load) begin
        cnt_d = half;
        tog_d = 1'b1;
      end else if (run) begin
        if (cnt <= CNT_W'(1)) begin
          cnt_d = half;
          tog_d = ~tog;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tog <= 1'b0;
    end else begin
      cnt <= cnt_d;
      tog <= tog_d;
    end
  end

  assign tog_nxt = tog_d;

endmodule

// File: rtl/alarm_tone_gen.sv
// Turns the highest-priority zone alarm into a beeping zone-specific tone; all outputs registered,
// one edge from alarm_in to spk/active/busy. No backpressure; ena low freezes everything and mutes spk.
module alarm_tone_gen
  import alarm_pkg::*;
#(
  parameter int TONE1_HALF = 4,
  parameter int TONE2_HALF = 6,
  parameter int TONE3_HALF = 8,
  parameter int BEEP_ON    = 32,
  parameter int BEEP_OFF   = 16,
  parameter int CNT_W      = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  alarm_tone_gen_if.slave bus
);

  localparam int MAXV = (1 << CNT_W) - 1;

  if (CNT_W < 1 || CNT_W > 30 ||
      TONE1_HALF < 1 || TONE1_HALF > MAXV || TONE2_HALF < 1 || TONE2_HALF > MAXV ||
      TONE3_HALF < 1 || TONE3_HALF > MAXV || BEEP_ON < 1 || BEEP_ON > MAXV ||
      BEEP_OFF < 1 || BEEP_OFF > MAXV) begin : g_param_err
    $error("alarm_tone_gen: length parameter out of range for CNT_W");
  end

  state_t           state, nxt;
  logic [CNT_W-1:0] beep_cnt, beep_nxt;
  logic [CNT_W-1:0] half;
  logic [2:0]       grant, sel, active_q, active_d;
  logic             tone_load, tog_nxt;
  logic             spk_q, spk_d, busy_q, busy_d;

  assign grant = prio_grant(bus.alarm_in);

  // A fresh load takes the new winner's pitch; reloads mid-burst use the latched zone.
  always_comb begin
    sel = tone_load ? grant : active_q;
    if (sel[ZONE1])      half = CNT_W'(TONE1_HALF);
    else if (sel[ZONE2]) half = CNT_W'(TONE2_HALF);
    else                 half = CNT_W'(TONE3_HALF);
  end

  tone_divider #(.CNT_W(CNT_W)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold    (!bus.ena),
    .load    (tone_load),
    .run     (state == TONE),
    .half    (half),
    .tog_nxt (tog_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beep_cnt <= '0;
    end else begin
      state    <= nxt;
      beep_cnt <= beep_nxt;
    end
  end

  // Alarm drop in TONE beats burst expiry; a drop in GAP waits for the gap to finish.
  always_comb begin
    nxt       = state;
    beep_nxt  = beep_cnt;
    tone_load = 1'b0;
    if (bus.ena) begin
      unique case (state)
        IDLE: begin
          if (|bus.alarm_in) begin
            nxt       = TONE;
            beep_nxt  = CNT_W'(BEEP_ON);
            tone_load = 1'b1;
          end
        end
        TONE: begin
          if (bus.alarm_in == 3'b000) begin
            nxt      = IDLE;
            beep_nxt = '0;
          end else if (beep_cnt <= CNT_W'(1)) begin
            nxt      = GAP;
            beep_nxt = CNT_W'(BEEP_OFF);
          end else begin
            beep_nxt = beep_cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (beep_cnt <= CNT_W'(1)) begin
            if (|bus.alarm_in) begin
              nxt       = TONE;
              beep_nxt  = CNT_W'(BEEP_ON);
              tone_load = 1'b1;
            end else begin
              nxt      = IDLE;
              beep_nxt = '0;
            end
          end else begin
            beep_nxt = beep_cnt - CNT_W'(1);
          end
        end
        default: begin
          nxt      = IDLE;
          beep_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    active_d = active_q;
    if (tone_load)        active_d = grant;
    else if (nxt == IDLE) active_d = 3'b000;
    busy_d = (nxt != IDLE);
    spk_d  = bus.ena && (nxt == TONE) && tog_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 3'b000;
      busy_q   <= 1'b0;
      spk_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      busy_q   <= busy_d;
      spk_q    <= spk_d;
    end
  end

  assign bus.spk    = spk_q;
  assign bus.active = active_q;
  assign bus.busy   = busy_q;

endmodule
